pc_sequencer: RTL

Instruction-sequencing controller that owns the program counter register's write port. It fetches each instruction from instruction memory over a req/ack handshake, decodes the opcode, and computes the next PC: sequential, branch target, or return address. It waits on the datapath for non-control instructions, then drives `pc_in`/`pc_wr` into the PC register and reads the current value back on `pc_out`.

---
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches over req/ack, decodes, and drives the PC write port.
// Optional one-deep CALL/RET link register is enabled by defining PC_SEQ_CALL_EN.
module pc_sequencer #(
   parameter int unsigned OPERAND_WIDTH = 11,
   parameter int unsigned OPCODE_WIDTH  = 5
) (
   input  logic                                  clock,
   input  logic                                  pc_reset,
   input  logic [OPERAND_WIDTH-1:0]              pc_out,
   input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instr_in,
   input  logic                                  mem_ack,
   input  logic                                  flag_z,
   input  logic                                  flag_n,
   input  logic                                  exec_done,
   output logic                                  mem_req,
   output logic                                  ir_wr,
   output logic [OPERAND_WIDTH-1:0]              pc_in,
   output logic                                  pc_wr,
   output logic                                  halted
);

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(5'b00000);
   localparam logic [OPCODE_WIDTH-1:0] OP_BR   = OPCODE_WIDTH'(5'b01000);
   localparam logic [OPCODE_WIDTH-1:0] OP_BZ   = OPCODE_WIDTH'(5'b01001);
   localparam logic [OPCODE_WIDTH-1:0] OP_BN   = OPCODE_WIDTH'(5'b01010);
   localparam logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(5'b01011);
   localparam logic [OPCODE_WIDTH-1:0] OP_RET  = OPCODE_WIDTH'(5'b01100);

   typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_e;

   state_e                   state_q, state_d;
   logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
   logic [OPERAND_WIDTH-1:0] operand_q, operand_d;
   logic                     flag_z_q, flag_z_d;
   logic                     flag_n_q, flag_n_d;
   logic [OPERAND_WIDTH-1:0] pc_inc;
`ifdef PC_SEQ_CALL_EN
   logic [OPERAND_WIDTH-1:0] link_q, link_d;
`endif

   assign pc_inc = pc_out + OPERAND_WIDTH'(1);

   always_ff @(posedge clock or posedge pc_reset) begin
      if (pc_reset) begin
         state_q   <= StIdle;
         opcode_q  <= '0;
         operand_q <= '0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
`ifdef PC_SEQ_CALL_EN
         link_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
`ifdef PC_SEQ_CALL_EN
         link_q    <= link_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
`ifdef PC_SEQ_CALL_EN
      link_d    = link_q;
`endif
      mem_req   = 1'b0;
      ir_wr     = 1'b0;
      pc_wr     = 1'b0;
      pc_in     = '0;
      halted    = 1'b0;

      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_wr     = 1'b1;
               opcode_d  = instr_in[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
               operand_d = instr_in[OPERAND_WIDTH-1:0];
               state_d   = StDecode;
            end
         end
         StDecode: begin
            // Flags are frozen here so later datapath activity cannot redirect a branch.
            flag_z_d = flag_z;
            flag_n_d = flag_n;
            state_d  = StExec;
         end
         StExec: begin
            case (opcode_q)
               OP_HLT: state_d = StHalt;
               OP_BR: begin
                  pc_wr   = 1'b1;
                  pc_in   = operand_q;
                  state_d = StFetch;
               end
               OP_BZ: begin
                  pc_wr   = 1'b1;
                  pc_in   = flag_z_q ? operand_q : pc_inc;
                  state_d = StFetch;
               end
               OP_BN: begin
                  pc_wr   = 1'b1;
                  pc_in   = flag_n_q ? operand_q : pc_inc;
                  state_d = StFetch;
               end
               OP_CALL: begin
                  pc_wr   = 1'b1;
                  state_d = StFetch;
`ifdef PC_SEQ_CALL_EN
                  pc_in   = operand_q;
                  link_d  = pc_inc;
`else
                  pc_in   = pc_inc;
`endif
               end
               OP_RET: begin
                  pc_wr   = 1'b1;
                  state_d = StFetch;
`ifdef PC_SEQ_CALL_EN
                  pc_in   = link_q;
`else
                  pc_in   = pc_inc;
`endif
               end
               default: begin
                  if (exec_done) begin
                     pc_wr   = 1'b1;
                     pc_in   = pc_inc;
                     state_d = StFetch;
                  end
               end
            endcase
         end
         StHalt: halted = 1'b1;
         default: state_d = StIdle;
      endcase
   end

endmodule
